// File: rtl/signal_demod_pkg.sv
// Shared types and helpers for the signal_demodulation receive chain.
// Contents: alignment FSM state enum, datapath width constants and the
// 16-bit saturation helper used on the despread/rescaled sample.
package signal_demod_pkg;

  localparam int DOUT_W = 16;
  localparam int RX_W   = 32;
  localparam int PRN_W  = 16;
  localparam int RES_W  = RX_W + 1;  // rx - zext(prn) needs one extra bit

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } demod_state_e;

  // Clamp a 33-bit signed value into the signed 16-bit output range.
  function automatic logic signed [DOUT_W-1:0] sat16(input logic signed [RES_W-1:0] x);
    logic signed [DOUT_W-1:0] r;
    if (x > 33'sd32767) begin
      r = 16'sh7FFF;
    end else if (x < -33'sd32768) begin
      r = 16'sh8000;
    end else begin
      r = x[DOUT_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/signal_demodulation_prn_delay_line.sv
// prn_delay_line: ring buffer holding the last DEPTH local PRN samples so the
// replica can be delayed to line up with the received stream.
// Ports:
//   clk, rst_n  clock / asynchronous active-low reset (clears buffer and pointer)
//   wr_en       write wr_data at the write pointer and advance it
//   wr_data     local PRN sample
//   delay       requested delay in samples (0..DEPTH-1)
//   rd_data     delayed PRN; delay 0 bypasses the buffer and returns wr_data
module prn_delay_line #(
  parameter int DEPTH = 16,
  parameter int PRN_W = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [PRN_W-1:0] wr_data,
  input  logic [AW-1:0]    delay,
  output logic [PRN_W-1:0] rd_data
);

  logic [PRN_W-1:0] prn_mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
    end else if (wr_en) begin
      wr_ptr_reg <= wr_ptr_reg + 1'b1;  // DEPTH is a power of two, wraps naturally
    end
  end

  // One register per entry so reset can clear the whole line.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        prn_mem[gi] <= '0;
      end else if (wr_en && (wr_ptr_reg == AW'(gi))) begin
        prn_mem[gi] <= wr_data;
      end
    end
  end

  // Entry written 'delay' samples ago; modulo DEPTH by pointer width.
  assign rd_addr = wr_ptr_reg - delay;
  assign rd_data = (delay == '0) ? wr_data : prn_mem[rd_addr];

endmodule

// File: rtl/signal_demodulation.sv
// signal_demodulation: strips the chaotic-PRN mask from the received stream
// (rx = DDS*2^k_shift + PRN) and recovers the 16-bit DDS sample.
// A SEARCH/VERIFY/LOCKED FSM steps the local PRN delay until the residue's
// low k_shift bits vanish consistently.
// Ports:
//   clk, rst_n    clock / asynchronous active-low reset
//   in_valid      rx_data and prn_in valid this cycle
//   rx_data       received sample (signed 32)
//   prn_in        local PRN replica sample (unsigned 16)
//   k_shift       log2 of the scaling factor, static while operating
//   dout          recovered DDS sample (signed 16), held between strobes
//   dout_valid    one-cycle strobe for dout
//   locked        FSM is LOCKED
//   align_delay   PRN delay currently applied
// Optional build macro DEMOD_STATS_EN adds lock_loss_cnt and miss_total
// (saturating counters, cleared only by reset).
module signal_demodulation
  import signal_demod_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int LOCK_CNT   = 8,
  parameter int UNLOCK_CNT = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic signed [RX_W-1:0]    rx_data,
  input  logic [PRN_W-1:0]          prn_in,
  input  logic [4:0]                k_shift,
  output logic signed [DOUT_W-1:0]  dout,
  output logic                      dout_valid,
  output logic                      locked,
  output logic [$clog2(DEPTH)-1:0]  align_delay
`ifdef DEMOD_STATS_EN
  ,
  output logic [15:0]               lock_loss_cnt,
  output logic [15:0]               miss_total
`endif
);

  localparam int AW     = $clog2(DEPTH);
  localparam int HIT_W  = $clog2(LOCK_CNT + 1);
  localparam int MISS_W = $clog2(UNLOCK_CNT + 1);
  localparam logic [HIT_W-1:0]  LOCK_CNT_V   = HIT_W'(LOCK_CNT);
  localparam logic [MISS_W-1:0] UNLOCK_CNT_V = MISS_W'(UNLOCK_CNT);

  // ---------------- datapath ----------------
  logic [PRN_W-1:0]         prn_aligned;
  logic [AW-1:0]            delay_reg, delay_next;

  logic                     v_s1_reg, v_s2_reg;
  logic signed [RX_W-1:0]   rx_s1_reg;
  logic [PRN_W-1:0]         prn_s1_reg;
  logic signed [RES_W-1:0]  res_s2_reg;

  logic [RES_W-1:0]         res_mask;
  logic                     match_s3;
  logic signed [DOUT_W-1:0] q_s3;

  prn_delay_line #(
    .DEPTH (DEPTH),
    .PRN_W (PRN_W),
    .AW    (AW)
  ) u_delay (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (in_valid),
    .wr_data (prn_in),
    .delay   (delay_reg),
    .rd_data (prn_aligned)
  );

  // S1: capture rx and aligned PRN. S2: residue. Stages load only on valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_s1_reg   <= 1'b0;
      v_s2_reg   <= 1'b0;
      rx_s1_reg  <= '0;
      prn_s1_reg <= '0;
      res_s2_reg <= '0;
    end else begin
      v_s1_reg <= in_valid;
      v_s2_reg <= v_s1_reg;
      if (in_valid) begin
        rx_s1_reg  <= rx_data;
        prn_s1_reg <= prn_aligned;
      end
      if (v_s1_reg) begin
        res_s2_reg <= {rx_s1_reg[RX_W-1], rx_s1_reg} - {{(RES_W-PRN_W){1'b0}}, prn_s1_reg};
      end
    end
  end

  // S3 (combinational, registered into the outputs/FSM): the DDS term leaves
  // the low k_shift bits zero only when the PRN is correctly aligned.
  assign res_mask = (RES_W'(1) << k_shift) - RES_W'(1);
  assign match_s3 = ((res_s2_reg & res_mask) == '0);
  assign q_s3     = sat16(res_s2_reg >>> k_shift);

  // ---------------- alignment FSM ----------------
  demod_state_e        state_reg, state_next;
  logic [HIT_W-1:0]    hit_reg, hit_next;
  logic [MISS_W-1:0]   miss_reg, miss_next;
  logic [1:0]          blank_reg, blank_next;
  logic                eval_s3;
  logic                emit;
  logic                lost;
  logic                missed;
  logic signed [DOUT_W-1:0] dout_reg;
  logic                dout_valid_reg;

  // Results computed with a stale delay are swallowed via blank_reg.
  assign eval_s3 = v_s2_reg && (blank_reg == 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= SEARCH;
      hit_reg   <= '0;
      miss_reg  <= '0;
      blank_reg <= '0;
      delay_reg <= '0;
    end else begin
      state_reg <= state_next;
      hit_reg   <= hit_next;
      miss_reg  <= miss_next;
      blank_reg <= blank_next;
      delay_reg <= delay_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    hit_next   = hit_reg;
    miss_next  = miss_reg;
    blank_next = blank_reg;
    delay_next = delay_reg;
    if (v_s2_reg && (blank_reg != 2'd0)) begin
      blank_next = blank_reg - 2'd1;
    end else if (eval_s3) begin
      case (state_reg)
        SEARCH: begin
          if (match_s3) begin
            state_next = VERIFY;
            hit_next   = HIT_W'(1);
          end else begin
            delay_next = delay_reg + 1'b1;
            blank_next = 2'd2;
          end
        end
        VERIFY: begin
          if (match_s3) begin
            if (hit_reg + 1'b1 == LOCK_CNT_V) begin
              state_next = LOCKED;
              hit_next   = '0;
              miss_next  = '0;
            end else begin
              hit_next = hit_reg + 1'b1;
            end
          end else begin
            state_next = SEARCH;
            hit_next   = '0;
            delay_next = delay_reg + 1'b1;
            blank_next = 2'd2;
          end
        end
        LOCKED: begin
          if (match_s3) begin
            miss_next = '0;
          end else if (miss_reg + 1'b1 == UNLOCK_CNT_V) begin
            // Loss of lock keeps the delay: re-search starts from where we were.
            state_next = SEARCH;
            miss_next  = '0;
          end else begin
            miss_next = miss_reg + 1'b1;
          end
        end
        default: state_next = SEARCH;
      endcase
    end
  end

  always_comb begin
    emit   = eval_s3 && (state_reg == LOCKED);
    lost   = emit && (state_next == SEARCH);
    missed = eval_s3 && !match_s3;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_reg       <= '0;
      dout_valid_reg <= 1'b0;
    end else begin
      dout_valid_reg <= emit;
      if (emit) begin
        dout_reg <= q_s3;
      end
    end
  end

  assign dout        = dout_reg;
  assign dout_valid  = dout_valid_reg;
  assign locked      = (state_reg == LOCKED);
  assign align_delay = delay_reg;

`ifdef DEMOD_STATS_EN
  logic [15:0] lock_loss_cnt_reg;
  logic [15:0] miss_total_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_loss_cnt_reg <= '0;
      miss_total_reg    <= '0;
    end else begin
      if (lost && (lock_loss_cnt_reg != 16'hFFFF)) begin
        lock_loss_cnt_reg <= lock_loss_cnt_reg + 16'd1;
      end
      if (missed && (miss_total_reg != 16'hFFFF)) begin
        miss_total_reg <= miss_total_reg + 16'd1;
      end
    end
  end

  assign lock_loss_cnt = lock_loss_cnt_reg;
  assign miss_total    = miss_total_reg;
`endif

endmodule

// File: tb/tb_signal_demodulation.sv
// Self-checking bench for signal_demodulation: randomized PRN/DDS streams with
// random in_valid gaps, compared cycle by cycle against a behavioural model
// (sample-indexed PRN history, integer residue arithmetic, rule-level FSM).
module tb_signal_demodulation;

  localparam int DEPTH      = 16;
  localparam int LOCK_CNT   = 8;
  localparam int UNLOCK_CNT = 4;

  logic               clk;
  logic               rst_n;
  logic               in_valid;
  logic signed [31:0] rx_data;
  logic [15:0]        prn_in;
  logic [4:0]         k_shift;
  logic signed [15:0] dout;
  logic               dout_valid;
  logic               locked;
  logic [3:0]         align_delay;
`ifdef DEMOD_STATS_EN
  logic [15:0]        lock_loss_cnt;
  logic [15:0]        miss_total;
`endif

  signal_demodulation #(
    .DEPTH      (DEPTH),
    .LOCK_CNT   (LOCK_CNT),
    .UNLOCK_CNT (UNLOCK_CNT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .rx_data     (rx_data),
    .prn_in      (prn_in),
    .k_shift     (k_shift),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .locked      (locked),
    .align_delay (align_delay)
`ifdef DEMOD_STATS_EN
    ,
    .lock_loss_cnt (lock_loss_cnt),
    .miss_total    (miss_total)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int     k;                 // scaling exponent for the current test
  int     m_state;           // 0 search, 1 verify, 2 locked
  int     m_delay, m_hit, m_miss, m_blank, m_loss, m_misses;
  int     hist[$];           // every local PRN sample since reset
  int     lprn[$];           // stimulus copy of local PRN, for building rx
  bit     pv0, pv1;          // samples still travelling the 3-cycle latency
  longint pres0, pres1;
  bit     e_valid;
  longint e_dout;

  function automatic longint sat(input longint x);
    if (x > 32767) return 32767;
    if (x < -32768) return -32768;
    return x;
  endfunction

  task automatic model_reset();
    m_state = 0; m_delay = 0; m_hit = 0; m_miss = 0; m_blank = 0;
    hist.delete(); lprn.delete();
    pv0 = 0; pv1 = 0; pres0 = 0; pres1 = 0; e_valid = 0;
    // m_loss / m_misses only clear on reset as well
    m_loss = 0; m_misses = 0;
  endtask

  task automatic model_eval(input longint res);
    longint p, q;
    bit     match;
    p = longint'(1) << k;
    match = (res % p) == 0;
    q = res / p;
    if ((res % p != 0) && (res < 0)) q = q - 1;   // floor division
    q = sat(q);
    e_valid = 0;
    if (m_blank > 0) begin
      m_blank--;
      return;
    end
    if (!match) m_misses++;
    case (m_state)
      0: if (match) begin m_state = 1; m_hit = 1; end
         else begin m_delay = (m_delay + 1) % DEPTH; m_blank = 2; end
      1: if (match) begin
           m_hit++;
           if (m_hit == LOCK_CNT) begin m_state = 2; m_miss = 0; end
         end else begin
           m_state = 0; m_delay = (m_delay + 1) % DEPTH; m_blank = 2;
         end
      default: begin
        e_valid = 1;
        e_dout  = q;
        if (match) m_miss = 0;
        else begin
          m_miss++;
          if (m_miss == UNLOCK_CNT) begin m_state = 0; m_miss = 0; m_loss++; end
        end
      end
    endcase
  endtask

  // One clock: drive, clock, then update the model and compare.
  task automatic step(input bit v, input logic [31:0] rx, input logic [15:0] prn);
    longint res_new;
    int     n, aligned;
    in_valid = v; rx_data = rx; prn_in = prn; k_shift = k[4:0];
    @(posedge clk); #1;
    res_new = 0;
    if (v) begin
      hist.push_back(int'(prn));
      n = hist.size() - 1;
      aligned = (n >= m_delay) ? hist[n - m_delay] : 0;
      res_new = longint'($signed(rx)) - longint'(aligned);
    end
    e_valid = 0;
    if (pv1) model_eval(pres1);
    pv1 = pv0; pres1 = pres0;
    pv0 = v;   pres0 = res_new;
    check("dout_valid", dout_valid, e_valid);
    check("locked", locked, (m_state == 2));
    check("align_delay", align_delay, m_delay);
    if (e_valid) check("dout", dout, e_dout);
  endtask

  // One valid sample, optionally preceded by an idle cycle.
  task automatic feed_one(input int lag, input longint dds, input bit corrupt, input int prn_force);
    int          idx, pl;
    logic [15:0] prn;
    logic [31:0] rx;
    if ($urandom_range(0, 4) == 0) step(1'b0, $urandom, 16'($urandom));
    prn = (prn_force >= 0) ? 16'(prn_force) : 16'($urandom);
    lprn.push_back(int'(prn));
    idx = lprn.size() - 1;
    pl  = (idx >= lag) ? lprn[idx - lag] : 0;
    rx  = 32'(dds * (longint'(1) << k) + longint'(pl));
    if (corrupt) rx = rx ^ 32'd1;
    step(1'b1, rx, prn);
  endtask

  task automatic flush();
    step(1'b0, 32'd0, 16'd0);
    step(1'b0, 32'd0, 16'd0);
  endtask

  // Asynchronous reset: outputs must clear before the next clock edge.
  task automatic reset_dut(input string tag);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check({tag, "_dout"}, dout, 0);
    check({tag, "_dout_valid"}, dout_valid, 0);
    check({tag, "_locked"}, locked, 0);
    check({tag, "_align"}, align_delay, 0);
`ifdef DEMOD_STATS_EN
    check({tag, "_loss_cnt"}, lock_loss_cnt, 0);
    check({tag, "_miss_tot"}, miss_total, 0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; rx_data = '0; prn_in = '0; k_shift = '0;
    k = 10;
    model_reset();
    #2;
    reset_dut("reset");

    // T1: aligned stream, DDS = 100, k_shift = 10
    k = 10;
    for (int i = 0; i < 24; i++) feed_one(0, 100, 1'b0, -1);
    flush();
    check("t1_locked", locked, 1);
    check("t1_dout", dout, 100);
    check("t1_delay", align_delay, 0);

    // T4: 3 corrupt samples keep lock, 4 drop it with the delay untouched
    for (int i = 0; i < 3; i++) feed_one(0, 100, 1'b1, -1);
    flush();
    check("t4_hold", locked, 1);
    for (int i = 0; i < 6; i++) feed_one(0, 100, 1'b0, -1);
    for (int i = 0; i < 4; i++) feed_one(0, 100, 1'b1, -1);
    flush();
    check("t4_drop", locked, 0);
    check("t4_delay", align_delay, 0);
`ifdef DEMOD_STATS_EN
    check("t4_loss_cnt", lock_loss_cnt, 1);
    check("t4_miss_tot", miss_total, m_misses);
`endif

    // T2 + T6: PRN in rx lags by 5, random DDS; reset mid-VERIFY at delay 5
    reset_dut("t2_reset");
    k = 10;
    for (int i = 0; i < 200; i++) begin
      feed_one(5, longint'($signed(16'($urandom))), 1'b0, -1);
      if (m_state == 1 && m_delay == 5) break;
    end
    check("t6_in_verify", align_delay, 5);
    reset_dut("t6_reset");
    k = 10;
    for (int i = 0; i < 120; i++) feed_one(5, longint'($signed(16'($urandom))), 1'b0, -1);
    flush();
    check("t2_delay", align_delay, 5);
    check("t2_locked", locked, 1);

    // T3: most negative DDS with PRN 0xFFFF at k_shift 15
    reset_dut("t3_reset");
    k = 15;
    for (int i = 0; i < 16; i++) feed_one(0, -32768, 1'b0, 16'hFFFF);
    flush();
    check("t3_locked", locked, 1);
    check("t3_dout", dout, -32768);
    // async reset while LOCKED with a non-zero dout
    reset_dut("t3_mid_reset");

    // T5: k_shift 0, raw random rx, plus forced saturation in both directions
    k = 0;
    for (int i = 0; i < 20; i++) step(1'b1, $urandom, 16'($urandom));
    flush();
    check("t5_locked", locked, 1);
    step(1'b1, 32'h7FFF_FFFF, 16'h0000);
    flush();
    check("t5_sat_hi", dout, 32767);
    step(1'b1, 32'h8000_0000, 16'hFFFF);
    flush();
    check("t5_sat_lo", dout, -32768);
    step(1'b1, 32'd1234, 16'd34);
    flush();
    check("t5_small", dout, 1200);
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 3) == 0) step(1'b0, $urandom, 16'($urandom));
      step(1'b1, $urandom_range(0, 200000) - 100000, 16'($urandom));
    end
    flush();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
